// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_arbiter_pkg : shared encodings and defaults for the memory arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int DEF_BLOCK_WORDS = 8;
  localparam int DEF_CNT_W       = 4;
  localparam int MEM_LATENCY     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_FILL = 2'd1,
    ST_D_FILL = 2'd2
  } state_e;

  typedef enum logic {
    FILL_I = 1'b0,
    FILL_D = 1'b1
  } fill_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_beat_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_arbiter_beat_counter : per-fill word counter with last-beat detect
// Rev 1.0
// -----------------------------------------------------------------------------
module mem_arbiter_beat_counter #(
  parameter int BLOCK_WORDS = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = inc && (cnt_q == LAST_BEAT);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_arbiter : shares main memory between I/D cache fills and D-cache stores
// Rev 1.0
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_read,
  input  logic [15:0] i_mem_addr,
  input  logic        d_mem_read,
  input  logic [15:0] d_mem_addr,
  input  logic        d_mem_write,
  input  logic [15:0] d_wdata,
  input  logic        mem_data_valid,
  output logic        i_grant,
  output logic        d_grant,
  output logic        d_write_ack,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        spurious_valid
);

  state_e           state_q, state_d;
  fill_e            last_fill_q, last_fill_d;
  logic             spurious_q, spurious_d;

  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic             issue_inc, ret_inc;
  logic             issue_done, ret_done;
  logic             issue_room;
  logic             unused_cnt_sinks;

  assign issue_room = issue_cnt < CNT_W'(BLOCK_WORDS);
  assign ret_inc    = mem_data_valid && (state_q != ST_IDLE) && !rst;
  assign issue_inc  = mem_enable && !mem_wr;

  // Fill completion is decided by returned words only; issue count just caps reads.
  assign unused_cnt_sinks = issue_done ^ (^ret_cnt);

  mem_arbiter_beat_counter #(
    .BLOCK_WORDS (BLOCK_WORDS),
    .CNT_W       (CNT_W)
  ) u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (ret_done),
    .inc  (issue_inc),
    .cnt  (issue_cnt),
    .done (issue_done)
  );

  mem_arbiter_beat_counter #(
    .BLOCK_WORDS (BLOCK_WORDS),
    .CNT_W       (CNT_W)
  ) u_ret_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (ret_done),
    .inc  (ret_inc),
    .cnt  (ret_cnt),
    .done (ret_done)
  );

  always_comb begin
    state_d        = state_q;
    last_fill_d    = last_fill_q;
    spurious_d     = spurious_q;
    i_grant        = 1'b0;
    d_grant        = 1'b0;
    d_write_ack    = 1'b0;
    i_data_valid   = 1'b0;
    d_data_valid   = 1'b0;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    spurious_valid = spurious_q;

    unique case (state_q)
      ST_IDLE: begin
        spurious_d = spurious_q | mem_data_valid;
        if (d_mem_write) begin
          mem_enable  = 1'b1;
          mem_wr      = 1'b1;
          mem_addr    = d_mem_addr;
          mem_wdata   = d_wdata;
          d_write_ack = 1'b1;
        end else if (i_mem_read && d_mem_read) begin
          state_d = (last_fill_q == FILL_D) ? ST_I_FILL : ST_D_FILL;
        end else if (d_mem_read) begin
          state_d = ST_D_FILL;
        end else if (i_mem_read) begin
          state_d = ST_I_FILL;
        end
      end

      ST_I_FILL: begin
        i_grant      = 1'b1;
        mem_addr     = i_mem_addr;
        mem_enable   = i_mem_read && issue_room;
        i_data_valid = mem_data_valid;
        if (ret_done) begin
          state_d     = ST_IDLE;
          last_fill_d = FILL_I;
        end
      end

      ST_D_FILL: begin
        d_grant      = 1'b1;
        mem_addr     = d_mem_addr;
        mem_enable   = d_mem_read && issue_room;
        d_data_valid = mem_data_valid;
        if (ret_done) begin
          state_d     = ST_IDLE;
          last_fill_d = FILL_D;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset forces every output quiet in the reset cycle itself, not just after.
    if (rst) begin
      i_grant        = 1'b0;
      d_grant        = 1'b0;
      d_write_ack    = 1'b0;
      i_data_valid   = 1'b0;
      d_data_valid   = 1'b0;
      mem_enable     = 1'b0;
      mem_wr         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      spurious_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_fill_q <= FILL_D;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_fill_q <= last_fill_d;
      spurious_q  <= spurious_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mem_arbiter : randomized self-checking bench with a 4-cycle memory model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mem_read, d_mem_read, d_mem_write, mem_data_valid;
  logic [15:0] i_mem_addr, d_mem_addr, d_wdata;
  logic        i_grant, d_grant, d_write_ack, i_data_valid, d_data_valid;
  logic        mem_enable, mem_wr, spurious_valid;
  logic [15:0] mem_addr, mem_wdata;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner 0 = nobody, 1 = I-cache, 2 = D-cache.
  int   m_owner, m_issued, m_returned;
  bit   m_last_d, m_spur;
  bit   pipe [4];
  bit   inject_spur;
  logic e_ig, e_dg, e_ack, e_iv, e_dv, e_en, e_wr, e_spur;
  logic [15:0] e_addr, e_wdata;
  logic [7:0]  exp_vec, obs_vec;

  always #5 clk = ~clk;

  mem_arbiter #(.BLOCK_WORDS(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .d_mem_read(d_mem_read), .d_mem_addr(d_mem_addr),
    .d_mem_write(d_mem_write), .d_wdata(d_wdata),
    .mem_data_valid(mem_data_valid),
    .i_grant(i_grant), .d_grant(d_grant), .d_write_ack(d_write_ack),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .spurious_valid(spurious_valid)
  );

  function automatic void model_outputs();
    {e_ig, e_dg, e_ack, e_iv, e_dv, e_en, e_wr, e_spur} = '0;
    e_addr  = '0;
    e_wdata = '0;
    if (!rst) begin
      e_spur = m_spur;
      if (m_owner == 0) begin
        if (d_mem_write) begin
          e_en = 1; e_wr = 1; e_ack = 1; e_addr = d_mem_addr; e_wdata = d_wdata;
        end
      end else if (m_owner == 1) begin
        e_ig = 1; e_en = i_mem_read && (m_issued < BW); e_addr = i_mem_addr; e_iv = mem_data_valid;
      end else begin
        e_dg = 1; e_en = d_mem_read && (m_issued < BW); e_addr = d_mem_addr; e_dv = mem_data_valid;
      end
    end
    exp_vec = {e_ig, e_dg, e_ack, e_iv, e_dv, e_en, e_wr, e_spur};
  endfunction

  task automatic clear_inputs();
    i_mem_read = 0; d_mem_read = 0; d_mem_write = 0; inject_spur = 0;
    i_mem_addr = '0; d_mem_addr = '0; d_wdata = '0;
  endtask

  // Inputs are set at posedge+1; outputs are sampled at posedge+4.
  task automatic eval_cycle();
    mem_data_valid = pipe[3] | inject_spur;
    #3;
    model_outputs();
    obs_vec = {i_grant, d_grant, d_write_ack, i_data_valid, d_data_valid,
               mem_enable, mem_wr, spurious_valid};
  endtask

  task automatic step();
    logic issued_now;
    @(posedge clk);
    issued_now = e_en && !e_wr;
    if (rst) begin
      m_owner = 0; m_issued = 0; m_returned = 0; m_last_d = 1; m_spur = 0;
      for (int k = 0; k < 4; k++) pipe[k] = 0;
    end else begin
      if (m_owner == 0) begin
        if (mem_data_valid) m_spur = 1;
        if (!d_mem_write) begin
          if (i_mem_read && d_mem_read) m_owner = m_last_d ? 1 : 2;
          else if (d_mem_read)          m_owner = 2;
          else if (i_mem_read)          m_owner = 1;
        end
      end else begin
        if (e_en) m_issued++;
        if (mem_data_valid) begin
          m_returned++;
          if (m_returned == BW) begin
            m_last_d = (m_owner == 2);
            m_owner = 0; m_issued = 0; m_returned = 0;
          end
        end
      end
      pipe[3] = pipe[2]; pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = issued_now;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    eval_cycle();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      rst = 1; i_mem_read = 1; d_mem_read = 1; d_mem_write = 1; inject_spur = 1;
      d_mem_addr = 16'($urandom); d_wdata = 16'($urandom); i_mem_addr = 16'($urandom);
      eval_cycle();
      checks++;
      if (obs_vec !== 8'h00) begin
        failures++; $display("FAIL reset_outputs cyc=%0d got=%b want=00000000", c, obs_vec);
      end
      step();
    end
    clear_inputs(); rst = 0;
    eval_cycle();
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++; $display("FAIL reset_idle got=%b want=%b", obs_vec, exp_vec);
    end
    step();
  endtask

  task automatic test_i_fill();
    int n_iss = 0, n_iv = 0, n_dv = 0, first_g = -1, last_w = -1;
    logic g_after = 1'bx;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      i_mem_read = (n_iss < BW);
      i_mem_addr = 16'h0100 + 16'(2 * n_iss);
      eval_cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL i_fill_flags cyc=%0d got=%b want=%b", c, obs_vec, exp_vec);
      end
      if (mem_enable) begin
        checks++;
        if (mem_addr !== 16'h0100 + 16'(2 * n_iss) || mem_wr !== 1'b0) begin
          failures++; $display("FAIL i_fill_addr cyc=%0d got=%h want=%h", c, mem_addr, 16'h0100 + 16'(2 * n_iss));
        end
        n_iss++;
      end
      if (i_grant && first_g < 0) first_g = c;
      if (i_data_valid) begin
        n_iv++; last_w = c;
        checks++;
        if (mem_data_valid !== 1'b1) begin
          failures++; $display("FAIL i_valid_gated cyc=%0d got=%b want=1", c, mem_data_valid);
        end
      end
      if (d_data_valid) n_dv++;
      if (last_w >= 0 && c == last_w + 1) g_after = i_grant;
      step();
    end
    checks += 5;
    if (first_g !== 1) begin failures++; $display("FAIL i_grant_latency got=%0d want=1", first_g); end
    if (n_iss !== BW)  begin failures++; $display("FAIL i_read_count got=%0d want=%0d", n_iss, BW); end
    if (n_iv !== BW || n_dv !== 0) begin
      failures++; $display("FAIL i_return_count got=%0d/%0d want=%0d/0", n_iv, n_dv, BW);
    end
    if (last_w - first_g !== 11) begin failures++; $display("FAIL i_fill_latency got=%0d want=11", last_w - first_g); end
    if (g_after !== 1'b0) begin failures++; $display("FAIL i_grant_drop got=%b want=0", g_after); end
  endtask

  task automatic test_round_robin();
    int seq [3];
    int n_fill = 0;
    logic prev_g = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      i_mem_read = 1; d_mem_read = 1;
      i_mem_addr = 16'($urandom); d_mem_addr = 16'($urandom);
      eval_cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL rr_flags cyc=%0d got=%b want=%b", c, obs_vec, exp_vec);
      end
      if ((i_grant || d_grant) && !prev_g && n_fill < 3) begin
        seq[n_fill] = i_grant ? 1 : 2;
        n_fill++;
      end
      prev_g = i_grant | d_grant;
      step();
    end
    checks++;
    if (n_fill !== 3 || seq[0] !== 1 || seq[1] !== 2 || seq[2] !== 1) begin
      failures++; $display("FAIL rr_order got=%0d fills %0d,%0d,%0d want=3 fills 1,2,1", n_fill, seq[0], seq[1], seq[2]);
    end
  endtask

  task automatic test_store_during_fill();
    int n_iss = 0, ack_cyc = -1, ack_in_fill = 0, d_first = -1;
    logic acked = 0;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      i_mem_read  = (n_iss < BW);
      i_mem_addr  = 16'($urandom);
      d_mem_write = (c >= 2) && !acked;
      d_mem_addr  = d_mem_write ? 16'h2000 : 16'($urandom);
      d_wdata     = 16'hBEEF;
      d_mem_read  = (c >= 2);
      eval_cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL store_flags cyc=%0d got=%b want=%b", c, obs_vec, exp_vec);
      end
      if (e_ig && i_mem_read && mem_enable) n_iss++;
      if (d_write_ack && i_grant) ack_in_fill++;
      if (d_write_ack && ack_cyc < 0) begin
        ack_cyc = c;
        checks++;
        if (mem_wr !== 1'b1 || mem_addr !== 16'h2000 || mem_wdata !== 16'hBEEF) begin
          failures++; $display("FAIL store_access wr=%b addr=%h data=%h want wr=1 addr=2000 data=beef", mem_wr, mem_addr, mem_wdata);
        end
      end
      if (d_grant && d_first < 0) d_first = c;
      if (e_ack) acked = 1;
      step();
    end
    checks += 3;
    if (ack_in_fill !== 0) begin failures++; $display("FAIL store_blocked got=%0d acks want=0", ack_in_fill); end
    if (ack_cyc !== 13)    begin failures++; $display("FAIL store_ack_cycle got=%0d want=13", ack_cyc); end
    if (d_first !== 15)    begin failures++; $display("FAIL store_before_dread got=%0d want=15", d_first); end
  endtask

  task automatic test_issue_limit();
    int n_en = 0, n_dv = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      d_mem_read = (c <= 13);
      d_mem_addr = 16'($urandom);
      eval_cycle();
      checks++;
      if (obs_vec !== exp_vec || (e_en && mem_addr !== e_addr)) begin
        failures++; $display("FAIL limit_flags cyc=%0d got=%b/%h want=%b/%h", c, obs_vec, mem_addr, exp_vec, e_addr);
      end
      if (mem_enable) n_en++;
      if (d_data_valid) n_dv++;
      step();
    end
    checks++;
    if (n_en !== BW || n_dv !== BW) begin
      failures++; $display("FAIL limit_count got=%0d reads/%0d words want=%0d/%0d", n_en, n_dv, BW, BW);
    end
  endtask

  task automatic test_reset_mid_fill();
    int n_dv = 0, n_iv = 0, i_iss = 0, i_first = -1, rst_cyc = -1;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      clear_inputs();
      rst = (rst_cyc < 0) && (n_dv == 3);
      if (rst) rst_cyc = c;
      d_mem_read = (rst_cyc < 0);
      d_mem_addr = 16'($urandom);
      i_mem_read = (rst_cyc >= 0) && (c > rst_cyc) && (i_iss < BW);
      i_mem_addr = 16'($urandom);
      eval_cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL midrst_flags cyc=%0d got=%b want=%b", c, obs_vec, exp_vec);
      end
      if (d_data_valid) n_dv++;
      if (i_data_valid) n_iv++;
      if (i_grant && i_mem_read && mem_enable) i_iss++;
      if (i_grant && i_first < 0) i_first = c;
      step();
    end
    rst = 0;
    checks += 3;
    if (rst_cyc !== 8)  begin failures++; $display("FAIL midrst_point got=%0d want=8", rst_cyc); end
    if (i_first !== 10) begin failures++; $display("FAIL midrst_regrant got=%0d want=10", i_first); end
    if (n_iv !== BW)    begin failures++; $display("FAIL midrst_refill got=%0d want=%0d", n_iv, BW); end
  endtask

  task automatic test_spurious();
    int n_v = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      inject_spur = (c == 1);
      eval_cycle();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL spur_flags cyc=%0d got=%b want=%b", c, obs_vec, exp_vec);
      end
      if (i_data_valid || d_data_valid) n_v++;
      step();
    end
    inject_spur = 0;
    checks += 2;
    if (n_v !== 0 || spurious_valid !== 1'b1) begin
      failures++; $display("FAIL spur_sticky got=%0d fwd/%b want=0 fwd/1", n_v, spurious_valid);
    end
    do_reset();
    eval_cycle();
    if (spurious_valid !== 1'b0) begin
      failures++; $display("FAIL spur_clear got=%b want=0", spurious_valid);
    end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      i_mem_read  = ($urandom % 3) != 0;
      d_mem_read  = ($urandom % 3) != 0;
      d_mem_write = ($urandom % 5) == 0;
      i_mem_addr  = 16'($urandom);
      d_mem_addr  = 16'($urandom);
      d_wdata     = 16'($urandom);
      eval_cycle();
      checks++;
      if (obs_vec !== exp_vec || (e_en && mem_addr !== e_addr) || (e_wr && mem_wdata !== e_wdata)) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b/%h/%h want=%b/%h/%h", c, obs_vec, mem_addr, mem_wdata, exp_vec, e_addr, e_wdata);
      end
      step();
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    mem_data_valid = 0;
    m_owner = 0; m_issued = 0; m_returned = 0; m_last_d = 1; m_spur = 0;
    for (int k = 0; k < 4; k++) pipe[k] = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_i_fill();
    test_round_robin();
    test_store_during_fill();
    test_issue_limit();
    test_reset_mid_fill();
    test_spurious();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single 4-cycle-latency, pipelined main memory between the I-cache fill FSM and the D-cache fill FSM, plus D-cache write-through stores.
- A fill, once granted, owns the memory until all BLOCK_WORDS words have been returned.
- The arbiter steers mem_data_valid back to the owning cache only.
- Sits between both cache controllers and the memory model at the top of the memory system.

Parameters:
BLOCK_WORDS, 8, 16-bit words per cache block (one read issued and one word returned per word)
CNT_W, 4, width of issue/return counters (must hold BLOCK_WORDS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
i_mem_read  in  1  I-cache fill FSM read request for current word
i_mem_addr  in  16  I-cache word address
d_mem_read  in  1  D-cache fill FSM read request
d_mem_addr  in  16  D-cache word address
d_mem_write  in  1  D-cache write-through store request
d_wdata  in  16  store data
mem_data_valid  in  1  memory returned a word this cycle
i_grant  out  1  I-cache owns memory; its read is accepted when i_mem_read & i_grant
d_grant  out  1  D-cache owns memory for a fill
d_write_ack  out  1  store accepted this cycle
i_data_valid  out  1  returned word belongs to I-cache
d_data_valid  out  1  returned word belongs to D-cache
mem_enable  out  1  memory access this cycle
mem_wr  out  1  write (1) or read (0)
mem_addr  out  16  memory address
mem_wdata  out  16  memory write data
spurious_valid  out  1  sticky: mem_data_valid seen with no fill outstanding

Behaviour:
- Reset (sync, any state, including mid-fill): state=IDLE, issue_cnt=ret_cnt=0, last_fill=D, spurious_valid=0. All outputs 0.
- States: IDLE, I_FILL, D_FILL; 2-bit encoding.
- IDLE, per cycle, in priority order:
  - d_mem_write: mem_enable=1, mem_wr=1, mem_addr=d_mem_addr, mem_wdata=d_wdata, d_write_ack=1 in the same cycle; stay IDLE.
  - Else both reads pending: go to the fill opposite last_fill (round-robin).
  - Else d_mem_read -> D_FILL; else i_mem_read -> I_FILL.
  - The requesting cycle is never accepted as a memory access. Grant rises the next cycle.
- Stores are never accepted outside IDLE; d_write_ack=0 and the D-cache holds d_mem_write.
- X_FILL (X = I or D):
  - x_grant=1.
  - mem_enable = x_mem_read & (issue_cnt < BLOCK_WORDS), mem_wr=0, mem_addr=x_mem_addr.
  - issue_cnt increments on each accepted read.
  - The other requester's inputs are ignored; it sees grant=0 and must hold.
- Return path:
  - Each mem_data_valid in X_FILL asserts x_data_valid combinationally in the same cycle and increments ret_cnt.
  - When mem_data_valid arrives with ret_cnt==BLOCK_WORDS-1: next state=IDLE, counters clear, last_fill=X.
  - Grant drops the cycle after the final word. The new arbitration decision is made in that IDLE cycle.
- mem_data_valid in IDLE: not forwarded; spurious_valid set (sticky until rst).
- Issue limit: reads beyond BLOCK_WORDS in one fill are blocked (mem_enable=0).
- Latency:
  - Request to grant: 1 cycle.
  - Grant to final word: BLOCK_WORDS + MEM_LATENCY - 1 = 11 cycles when the requester issues back-to-back.
  - Full fill occupancy: 12 cycles plus 1 IDLE arbitration cycle.
- Counter arithmetic: unsigned CNT_W; wrap never occurs because both counters clear at completion.

Decomposition:
- Shared include (mem_defs): state encodings ST_IDLE/ST_I_FILL/ST_D_FILL, BLOCK_WORDS, MEM_LATENCY=4.
- One natural sub-module: beat_counter (CNT_W-bit counter with inc, sync clear, and done = (cnt==BLOCK_WORDS-1)&inc). Instantiated twice, for issue and for return.
- FSM and muxing stay in mem_arbiter.

Test Plan:
- I-only fill: i_mem_read from cycle 0, addrs 0x0100..0x010E.
  -> i_grant rises cycle 1; 8 reads at 0x0100+2k.
  -> i_data_valid 8 times, with mem_data_valid only.
  -> i_grant low the cycle after the 8th word; d_data_valid never 1.
- Simultaneous d_mem_read and i_mem_read after reset (last_fill=D):
  -> I_FILL first.
  -> Then, with both still requesting, D_FILL.
  -> Then I again: alternation confirmed over 3 fills.
- Store during I_FILL: d_mem_write=1, addr 0x2000, wdata 0xBEEF.
  -> d_write_ack=0 until I_FILL completes.
  -> Then one cycle mem_wr=1, mem_addr=0x2000, mem_wdata=0xBEEF, d_write_ack=1.
  -> Store takes precedence over a pending d_mem_read.
- D-cache holds d_mem_read 12 cycles in D_FILL:
  -> mem_enable asserted exactly 8 times; no 9th read issued.
- rst asserted after the 3rd returned word of a D_FILL:
  -> Next cycle state IDLE, all grants/valids 0, counters 0.
  -> A new i_mem_read is granted 1 cycle later.
- mem_data_valid pulsed in IDLE:
  -> No i/d_data_valid; spurious_valid=1 and held until rst.
